// File: rtl/sram_lsu_pkg.sv
// Shared types and constants for the SRAM load/store initiator.
// Optional statistics counters are enabled with SRAM_LSU_STATS_EN.
package sram_lsu_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    RD_ISSUE,
    RD_WAIT,
    RESP
  } lsu_state_t;

  localparam logic [15:0] STAT_MAX = 16'hFFFF;

  // Wide enough for READ_LATENCY up to 4.
  localparam int unsigned LAT_W = 3;

  function automatic int unsigned addr_w(input int unsigned rf_bits);
    return 2 ** rf_bits;
  endfunction

endpackage

// File: rtl/sram_lsu_stats.sv
// Saturating activity counters for sram_lsu (read strobes, write strobes,
// response stall cycles); only instantiated under SRAM_LSU_STATS_EN.
module sram_lsu_stats
  import sram_lsu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rd_strobe,
  input  logic        wr_strobe,
  input  logic        stall,
  output logic [15:0] stat_reads,
  output logic [15:0] stat_writes,
  output logic [15:0] stat_stall
);

  logic [15:0] reads_q, reads_d;
  logic [15:0] writes_q, writes_d;
  logic [15:0] stall_q, stall_d;

  always_comb begin
    reads_d  = reads_q;
    writes_d = writes_q;
    stall_d  = stall_q;
    if (rd_strobe && (reads_q != STAT_MAX)) reads_d = reads_q + 16'd1;
    if (wr_strobe && (writes_q != STAT_MAX)) writes_d = writes_q + 16'd1;
    if (stall && (stall_q != STAT_MAX)) stall_d = stall_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      reads_q  <= '0;
      writes_q <= '0;
      stall_q  <= '0;
    end else begin
      reads_q  <= reads_d;
      writes_q <= writes_d;
      stall_q  <= stall_d;
    end
  end

  assign stat_reads  = reads_q;
  assign stat_writes = writes_q;
  assign stat_stall  = stall_q;

endmodule

// File: rtl/sram_lsu.sv
// Load/store initiator for the lab SRAM: single-beat writes, burst reads with
// a fixed read latency, valid/ready read responses. Stats ports: SRAM_LSU_STATS_EN.
module sram_lsu
  import sram_lsu_pkg::*;
#(
  parameter int unsigned N              = 8,
  parameter int unsigned RF_addressBits = 3,
  parameter int unsigned READ_LATENCY   = 1,
  parameter int unsigned BURST_BITS     = 2,
  localparam int unsigned ADDR_W        = addr_w(RF_addressBits)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [BURST_BITS-1:0] req_len,
  input  logic [N-1:0]          req_wdata,
  output logic                  wr_done,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [N-1:0]          rsp_data,
  output logic                  rsp_last,
  output logic                  SRAM_readEnable,
  output logic                  SRAM_writeEnable,
  output logic [ADDR_W-1:0]     SRAM_address,
  output logic [N-1:0]          SRAM_data_in,
  input  logic [N-1:0]          SRAM_data
`ifdef SRAM_LSU_STATS_EN
  ,
  output logic [15:0]           stat_reads,
  output logic [15:0]           stat_writes,
  output logic [15:0]           stat_stall
`endif
);

  lsu_state_t            state_q, state_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [N-1:0]          wdata_q, wdata_d;
  logic [BURST_BITS-1:0] beats_q, beats_d;
  logic [LAT_W-1:0]      lat_q, lat_d;
  logic [N-1:0]          hold_q, hold_d;

  // addr_q/wdata_q drive the SRAM pins directly, so they only change on
  // entry to a strobe state and otherwise hold their last value.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    beats_d = beats_q;
    lat_d   = lat_q;
    hold_d  = hold_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d = req_addr;
          if (req_write) begin
            wdata_d = req_wdata;
            state_d = WRITE;
          end else begin
            beats_d = req_len;
            state_d = RD_ISSUE;
          end
        end
      end
      WRITE: begin
        state_d = IDLE;
      end
      RD_ISSUE: begin
        lat_d   = LAT_W'(READ_LATENCY);
        state_d = RD_WAIT;
      end
      RD_WAIT: begin
        lat_d = lat_q - LAT_W'(1);
        if (lat_q <= LAT_W'(1)) begin
          lat_d   = '0;
          hold_d  = SRAM_data;
          state_d = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          if (beats_q != '0) begin
            addr_d  = addr_q + ADDR_W'(1);
            beats_d = beats_q - BURST_BITS'(1);
            state_d = RD_ISSUE;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      beats_q <= '0;
      lat_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      beats_q <= beats_d;
      lat_q   <= lat_d;
      hold_q  <= hold_d;
    end
  end

  assign req_ready        = (state_q == IDLE);
  assign SRAM_writeEnable = (state_q == WRITE);
  assign wr_done          = (state_q == WRITE);
  assign SRAM_readEnable  = (state_q == RD_ISSUE);
  assign rsp_valid        = (state_q == RESP);
  assign rsp_last         = (state_q == RESP) && (beats_q == '0);
  assign rsp_data         = hold_q;
  assign SRAM_address     = addr_q;
  assign SRAM_data_in     = wdata_q;

`ifdef SRAM_LSU_STATS_EN
  sram_lsu_stats u_stats (
    .clk         (clk),
    .rst_n       (rst_n),
    .rd_strobe   (SRAM_readEnable),
    .wr_strobe   (SRAM_writeEnable),
    .stall       (rsp_valid && !rsp_ready),
    .stat_reads  (stat_reads),
    .stat_writes (stat_writes),
    .stat_stall  (stat_stall)
  );
`endif

endmodule

// File: tb/tb_sram_lsu.sv
// Directed, table-driven bench for sram_lsu with a behavioural SRAM model.
module tb_sram_lsu;

  localparam int unsigned RL = 1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid, req_ready, req_write;
  logic [7:0] req_addr;
  logic [1:0] req_len;
  logic [7:0] req_wdata;
  logic       wr_done, rsp_valid, rsp_ready, rsp_last;
  logic [7:0] rsp_data;
  logic       SRAM_readEnable, SRAM_writeEnable;
  logic [7:0] SRAM_address, SRAM_data_in, SRAM_data;
`ifdef SRAM_LSU_STATS_EN
  logic [15:0] stat_reads, stat_writes, stat_stall;
`endif

  always #5 clk = ~clk;

  sram_lsu #(
    .N              (8),
    .RF_addressBits (3),
    .READ_LATENCY   (RL),
    .BURST_BITS     (2)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_write        (req_write),
    .req_addr         (req_addr),
    .req_len          (req_len),
    .req_wdata        (req_wdata),
    .wr_done          (wr_done),
    .rsp_valid        (rsp_valid),
    .rsp_ready        (rsp_ready),
    .rsp_data         (rsp_data),
    .rsp_last         (rsp_last),
    .SRAM_readEnable  (SRAM_readEnable),
    .SRAM_writeEnable (SRAM_writeEnable),
    .SRAM_address     (SRAM_address),
    .SRAM_data_in     (SRAM_data_in),
    .SRAM_data        (SRAM_data)
`ifdef SRAM_LSU_STATS_EN
    ,
    .stat_reads       (stat_reads),
    .stat_writes      (stat_writes),
    .stat_stall       (stat_stall)
`endif
  );

  // SRAM model: data for a read strobe sampled at edge E is valid at edge E+RL.
  logic [7:0] mem [256];
  logic [7:0] pipe [RL];
  always @(posedge clk) begin
    if (SRAM_writeEnable) mem[SRAM_address] <= SRAM_data_in;
    if (SRAM_readEnable) pipe[0] <= mem[SRAM_address];
    for (int i = 1; i < RL; i++) pipe[i] <= pipe[i-1];
  end
  assign SRAM_data = pipe[RL-1];

  // Strobe monitor
  int         cyc = 0;
  int         excl_err = 0;
  logic [7:0] rd_addr_q [$];
  int         rd_cyc_q [$];
  always @(negedge clk) begin
    cyc++;
    if (SRAM_readEnable) begin
      rd_addr_q.push_back(SRAM_address);
      rd_cyc_q.push_back(cyc);
    end
    if (SRAM_readEnable && SRAM_writeEnable) excl_err++;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic            wr;
    logic [7:0]      addr;
    logic [1:0]      len;
    logic [7:0]      wdata;
    logic [3:0][7:0] exp;
    int              stall_beat;
    int              stall_cyc;
  } vec_t;

  function automatic vec_t mkv(input logic wr, input logic [7:0] addr, input logic [1:0] len,
                               input logic [7:0] wdata, input logic [31:0] exp,
                               input int stall_beat, input int stall_cyc);
    vec_t v;
    v.wr = wr; v.addr = addr; v.len = len; v.wdata = wdata;
    v.exp = exp; v.stall_beat = stall_beat; v.stall_cyc = stall_cyc;
    return v;
  endfunction

  function automatic logic [31:0] out_vec();
    return {2'b0, req_ready, wr_done, rsp_valid, rsp_last, SRAM_readEnable,
            SRAM_writeEnable, SRAM_address, SRAM_data_in, rsp_data};
  endfunction

  localparam logic [31:0] RESET_OUTS = {2'b0, 1'b1, 29'h0};

  task automatic run_write(input vec_t v);
    @(negedge clk);
    chk("wr_req_ready", req_ready, 1);
    req_valid = 1'b1; req_write = 1'b1; req_addr = v.addr; req_len = v.len; req_wdata = v.wdata;
    @(negedge clk);
    req_valid = 1'b0;
    chk("wr_strobe", SRAM_writeEnable, 1);
    chk("wr_addr", SRAM_address, v.addr);
    chk("wr_data", SRAM_data_in, v.wdata);
    chk("wr_done", wr_done, 1);
    chk("wr_no_rd", SRAM_readEnable, 0);
    @(negedge clk);
    chk("wr_single_cycle", {SRAM_writeEnable, wr_done, req_ready}, 3'b001);
    chk("wr_mem_readback", mem[v.addr], v.wdata);
  endtask

  task automatic run_read(input vec_t v);
    int n;
    rd_addr_q.delete();
    rd_cyc_q.delete();
    @(negedge clk);
    chk("rd_req_ready", req_ready, 1);
    req_valid = 1'b1; req_write = 1'b0; req_addr = v.addr; req_len = v.len; req_wdata = 8'h00;
    @(negedge clk);
    req_valid = 1'b0;
    for (int b = 0; b <= int'(v.len); b++) begin
      int t = 0;
      while (!rsp_valid && t < 20) begin
        @(negedge clk);
        t++;
      end
      if (!rsp_valid) begin
        chk("rsp_timeout", 0, 1);
        break;
      end
      chk("rsp_data", rsp_data, v.exp[b]);
      chk("rsp_last", rsp_last, (b == int'(v.len)) ? 1 : 0);
      if (b == v.stall_beat) begin
        rsp_ready = 1'b0;
        for (int s = 0; s < v.stall_cyc; s++) begin
          @(negedge clk);
          chk("stall_hold", {rsp_valid, rsp_data, SRAM_readEnable}, {1'b1, v.exp[b], 1'b0});
        end
        rsp_ready = 1'b1;
      end
      @(negedge clk);
    end
    chk("rd_idle_after", {req_ready, rsp_valid}, 2'b10);
    n = rd_addr_q.size();
    chk("rd_strobe_count", n, int'(v.len) + 1);
    for (int b = 0; b < n && b <= int'(v.len); b++) begin
      logic [7:0] ea;
      ea = v.addr + 8'(b);
      chk("rd_addr", rd_addr_q[b], ea);
      if (b > 0)
        chk("rd_spacing", rd_cyc_q[b] - rd_cyc_q[b-1],
            RL + 2 + ((b - 1 == v.stall_beat) ? v.stall_cyc : 0));
    end
  endtask

  vec_t vecs [13];

  initial begin
    int busy, bad, t;
    rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
    req_len = '0; req_wdata = '0; rsp_ready = 1'b1;

    vecs[0]  = mkv(1'b1, 8'h12, 2'd0, 8'hA5, 32'h0, -1, 0);
    vecs[1]  = mkv(1'b1, 8'h40, 2'd0, 8'h01, 32'h0, -1, 0);
    vecs[2]  = mkv(1'b1, 8'h41, 2'd3, 8'h02, 32'h0, -1, 0);
    vecs[3]  = mkv(1'b1, 8'h42, 2'd0, 8'h03, 32'h0, -1, 0);
    vecs[4]  = mkv(1'b1, 8'h43, 2'd0, 8'h04, 32'h0, -1, 0);
    vecs[5]  = mkv(1'b1, 8'hFE, 2'd0, 8'h11, 32'h0, -1, 0);
    vecs[6]  = mkv(1'b1, 8'hFF, 2'd0, 8'h22, 32'h0, -1, 0);
    vecs[7]  = mkv(1'b1, 8'h00, 2'd0, 8'h33, 32'h0, -1, 0);
    vecs[8]  = mkv(1'b1, 8'h01, 2'd0, 8'h44, 32'h0, -1, 0);
    vecs[9]  = mkv(1'b0, 8'h40, 2'd3, 8'h00, 32'h04030201, -1, 0);
    vecs[10] = mkv(1'b0, 8'h40, 2'd3, 8'h00, 32'h04030201, 1, 5);
    vecs[11] = mkv(1'b0, 8'hFE, 2'd3, 8'h00, 32'h44332211, -1, 0);
    vecs[12] = mkv(1'b0, 8'h12, 2'd0, 8'h00, 32'h000000A5, -1, 0);

    repeat (3) @(negedge clk);
    chk("reset_outputs", out_vec(), RESET_OUTS);
    rst_n = 1'b1;

    for (int i = 0; i < 13; i++) begin
      if (vecs[i].wr) run_write(vecs[i]);
      else run_read(vecs[i]);
    end

`ifdef SRAM_LSU_STATS_EN
    chk("stat_writes", stat_writes, 9);
    chk("stat_reads", stat_reads, 13);
    chk("stat_stall", stat_stall, 5);
`endif

    // Reset in the middle of a burst
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 8'h40; req_len = 2'd3;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("midburst_reset_outputs", out_vec(), RESET_OUTS);
`ifdef SRAM_LSU_STATS_EN
      chk("midburst_reset_stats", {stat_reads, stat_writes | stat_stall}, 32'h0);
`endif
    end
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("post_reset_quiet", {SRAM_readEnable, SRAM_writeEnable, rsp_valid, req_ready}, 4'b0001);
    end

    // Request held during a burst is accepted on the first IDLE cycle
    @(negedge clk);
    chk("busy_req_ready_start", req_ready, 1);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 8'h40; req_len = 2'd1;
    @(negedge clk);
    req_write = 1'b1; req_addr = 8'h80; req_wdata = 8'h5A;
    busy = 0; bad = 0; t = 0;
    while (!req_ready && t < 40) begin
      if (SRAM_writeEnable) bad++;
      busy++;
      @(negedge clk);
      t++;
    end
    chk("busy_cycles", busy, 2 * (RL + 2));
    chk("busy_no_early_write", bad, 0);
    @(negedge clk);
    req_valid = 1'b0;
    chk("held_req_write", {SRAM_writeEnable, SRAM_address, SRAM_data_in}, {1'b1, 8'h80, 8'h5A});
    @(negedge clk);
    chk("held_req_mem", mem[8'h80], 8'h5A);
    chk("strobes_exclusive", excl_err, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
